mux_mapas_sequencial: RTL and testbench
=======================================

// Module: mux_mapas_sequencial
// PURPOSE
//   Registered N-way map selector for the game display path. It holds N_MAPAS
//   map words of LARGURA bits each (a flattened input bus) and drives one of them on 'out'.
//   Manual mode: a 'pedir' request loads a map index. Auto mode: a prescaler advances the
//   index cyclically (attract/demo rotation). Sits between map storage and the display driver.
// PARAMETERS
//   LARGURA   7    bits per map word
//   N_MAPAS   4    number of maps (>=2)
//   SEL_W     2    index width, = $clog2(N_MAPAS)
//   DIV_MAX   25000000  clk cycles per auto step (>=2; benches override to 4)
// PORTS
//   clk        in   1                  system clock, all state on rising edge
//   reset      in   1                  synchronous, active-high
//   mapas      in   N_MAPAS*LARGURA    map k = mapas[k*LARGURA +: LARGURA]
//   modo       in   1                  0 = manual, 1 = auto rotation
//   pausa      in   1                  auto mode only: freezes prescaler
//   pedir      in   1                  1-cycle request: load sel_manual as index
//   sel_manual in   SEL_W              requested index
//   out        out  LARGURA            selected map word (registered)
//   indice     out  SEL_W              current index (registered)
//   troca      out  1                  1-cycle pulse on the edge where indice changes
// BEHAVIOUR
//   - Reset (sync, active-high): indice=0, out=0, troca=0, contador=0. Reset wins over
//     every other input in the same cycle.
//   - out <= mapas slice of indice_next each cycle. out and indice update on the same edge.
//     A change on mapas reaches out 1 cycle later.
//   - Request: pedir=1 and sel_manual<N_MAPAS -> indice_next=sel_manual, contador<=0.
//     Valid in both modes. sel_manual>=N_MAPAS -> request ignored, contador unaffected.
//   - Auto: modo=1 and pausa=0 -> contador increments each cycle. At contador==DIV_MAX-1:
//     tick, contador<=0, indice_next = (indice==N_MAPAS-1) ? 0 : indice+1 (wrap).
//     pausa=1 holds contador and suppresses tick.
//   - Manual: modo=0 -> contador held at 0, no ticks.
//   - Priority in one cycle: reset > valid pedir > auto tick. A tick coinciding with
//     a valid pedir is discarded, and the prescaler restarts.
//   - A change of modo (modo != modo_q) clears contador that cycle. No index change.
//   - troca <= (indice_next != indice). Requesting the current index gives no pulse.
//     The auto wrap N_MAPAS-1 -> 0 does pulse.
//   - No combinational path from inputs to outputs.
// STRUCTURE
//   - Package mapas_pkg: LARGURA_PADRAO=7 and MAPA_VAZIO='0 constants.
//   - Same package: function idx_valido(sel, n) for the index range check.
//   - Sub-module divisor_tick #(DIV_MAX): in clk, reset, en, clr.
//     Output tick is a 1-cycle pulse; holds the prescaler counter.
//   - Top holds indice/out/troca registers, modo_q, the priority mux and the
//     indexed part-select.
// TESTING (N_MAPAS=4, LARGURA=7, DIV_MAX=4)
//   - Reset: assert reset 2 cycles with mapas non-zero.
//     -> out=0, indice=0, troca=0. First cycle after release: out=mapas[0].
//   - Manual select: mapas={7'h63,7'h41,7'h1C,7'h7F}.
//     pedir with sel_manual=2 -> next edge indice=2, out=7'h41, troca=1 for 1 cycle.
//     pedir with sel_manual=2 again -> troca=0.
//   - Auto rotation: modo=1 from indice=2 -> indice 3 after 4 cycles,
//     then 0 (wrap, troca=1), then 1, at 4-cycle spacing.
//   - Pause and priority: pausa=1 for 10 cycles -> indice frozen, no troca.
//     pedir sel=1 in the tick cycle -> indice=1, next tick 4 cycles later.
//   - Out of range: N_MAPAS=3 build, pedir sel_manual=3 -> indice, out, troca unchanged.
//   - Reset mid-rotation: reset asserted when contador=2 -> indice=0, out=0.
//     After release, first tick is 4 cycles later.

Source files
------------

// File: rtl/mapas_pkg.sv
// rtl/mapas_pkg.sv - shared constants and index range check for the map selector
package mapas_pkg;

  localparam int LARGURA_PADRAO = 7;
  localparam logic [LARGURA_PADRAO-1:0] MAPA_VAZIO = '0;

  function automatic logic idx_valido(input int sel, input int n);
    return (sel >= 0) && (sel < n);
  endfunction

endpackage

// File: rtl/mux_mapas_sequencial_divisor_tick.sv
// rtl/mux_mapas_sequencial_divisor_tick.sv - prescaler producing a 1-cycle tick every DIV_MAX enabled cycles
module divisor_tick #(
  parameter int DIV_MAX = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam logic [CNT_W-1:0] FIM = CNT_W'(DIV_MAX - 1);

  logic [CNT_W-1:0] contador;

  // clr wins over en so a restart never coincides with a tick
  assign tick = en && !clr && (contador == FIM);

  always_ff @(posedge clk) begin
    if (reset) begin
      contador <= '0;
    end else if (clr) begin
      contador <= '0;
    end else if (en) begin
      if (contador == FIM) begin
        contador <= '0;
      end else begin
        contador <= contador + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mux_mapas_sequencial.sv
// rtl/mux_mapas_sequencial.sv - registered N-way map selector with manual request and auto rotation
module mux_mapas_sequencial
  import mapas_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO,
  parameter int N_MAPAS = 4,
  parameter int SEL_W   = 2,
  parameter int DIV_MAX = 25000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_MAPAS*LARGURA-1:0] mapas,
  input  logic                       modo,
  input  logic                       pausa,
  input  logic                       pedir,
  input  logic [SEL_W-1:0]           sel_manual,
  output logic [LARGURA-1:0]         out,
  output logic [SEL_W-1:0]           indice,
  output logic                       troca
);

  localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(N_MAPAS - 1);

  logic             modo_q;
  logic             pedido_valido;
  logic             tick;
  logic             div_en;
  logic             div_clr;
  logic [SEL_W-1:0] indice_next;

  assign pedido_valido = pedir && idx_valido(32'(sel_manual), N_MAPAS);
  assign div_en        = modo && !pausa;
  // manual mode, a fresh request or a mode change all restart the prescaler
  assign div_clr       = !modo || pedido_valido || (modo != modo_q);

  divisor_tick #(
    .DIV_MAX(DIV_MAX)
  ) u_divisor (
    .clk  (clk),
    .reset(reset),
    .en   (div_en),
    .clr  (div_clr),
    .tick (tick)
  );

  always_comb begin
    indice_next = indice;
    if (pedido_valido) begin
      indice_next = sel_manual;
    end else if (tick) begin
      indice_next = (indice == ULTIMO) ? '0 : indice + SEL_W'(1);
    end
  end

  // modo_q follows modo through reset so leaving reset is not seen as a mode change
  always_ff @(posedge clk) begin
    modo_q <= modo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      indice <= '0;
      out    <= LARGURA'(MAPA_VAZIO);
      troca  <= 1'b0;
    end else begin
      indice <= indice_next;
      out    <= mapas[32'(indice_next)*LARGURA +: LARGURA];
      troca  <= (indice_next != indice);
    end
  end

endmodule

// File: tb/tb_mux_mapas_sequencial.sv
// tb/tb_mux_mapas_sequencial.sv - directed self-checking bench for mux_mapas_sequencial
module tb_mux_mapas_sequencial;

  logic        clk = 1'b0;
  logic        reset;
  logic [27:0] mapas;
  logic        modo, pausa, pedir;
  logic [1:0]  sel_manual;
  logic [6:0]  out;
  logic [1:0]  indice;
  logic        troca;

  logic        b_reset;
  logic [20:0] b_mapas;
  logic        b_pedir;
  logic [1:0]  b_sel;
  logic [6:0]  b_out;
  logic [1:0]  b_indice;
  logic        b_troca;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [27:0] MAPAS_A = {7'h63, 7'h41, 7'h1C, 7'h7F};
  localparam logic [27:0] MAPAS_C = {7'h63, 7'h2A, 7'h1C, 7'h7F};

  always #5 clk = ~clk;

  mux_mapas_sequencial #(.LARGURA(7), .N_MAPAS(4), .SEL_W(2), .DIV_MAX(4)) dut (
    .clk(clk), .reset(reset), .mapas(mapas), .modo(modo), .pausa(pausa),
    .pedir(pedir), .sel_manual(sel_manual), .out(out), .indice(indice), .troca(troca)
  );

  mux_mapas_sequencial #(.LARGURA(7), .N_MAPAS(3), .SEL_W(2), .DIV_MAX(4)) dut3 (
    .clk(clk), .reset(b_reset), .mapas(b_mapas), .modo(1'b0), .pausa(1'b0),
    .pedir(b_pedir), .sel_manual(b_sel), .out(b_out), .indice(b_indice), .troca(b_troca)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; b_reset = 1'b1;
    mapas = MAPAS_A; b_mapas = {7'h33, 7'h22, 7'h11};
    modo = 1'b0; pausa = 1'b0; pedir = 1'b0; sel_manual = 2'd0;
    b_pedir = 1'b0; b_sel = 2'd0;
    step(2);
    chk("rst_out", 32'(out), 32'h0);
    chk("rst_indice", 32'(indice), 32'h0);
    chk("rst_troca", 32'(troca), 32'h0);
    chk("rst3_out", 32'(b_out), 32'h0);
    reset = 1'b0; b_reset = 1'b0;
    step();
    chk("rel_out", 32'(out), 32'h7F);
    chk("rel_troca", 32'(troca), 32'h0);

    // manual select
    pedir = 1'b1; sel_manual = 2'd2;
    step();
    pedir = 1'b0;
    chk("man_indice", 32'(indice), 32'h2);
    chk("man_out", 32'(out), 32'h41);
    chk("man_troca", 32'(troca), 32'h1);
    step();
    chk("man_troca_pulse", 32'(troca), 32'h0);
    pedir = 1'b1;
    step();
    pedir = 1'b0;
    chk("same_idx_troca", 32'(troca), 32'h0);
    chk("same_idx_indice", 32'(indice), 32'h2);

    // map data change propagates one cycle later
    mapas = MAPAS_C;
    step();
    chk("data_follow", 32'(out), 32'h2A);
    mapas = MAPAS_A;
    step();
    chk("data_restore", 32'(out), 32'h41);

    // manual mode never ticks
    step(9);
    chk("manual_hold", 32'(indice), 32'h2);

    // auto rotation: mode-change edge clears, then 4-cycle ticks
    modo = 1'b1;
    step(4);
    chk("auto_pre", 32'(indice), 32'h2);
    step();
    chk("auto_3", 32'(indice), 32'h3);
    chk("auto_3_out", 32'(out), 32'h63);
    chk("auto_3_troca", 32'(troca), 32'h1);
    step(3);
    chk("auto_3_hold", 32'(indice), 32'h3);
    chk("auto_3_notroca", 32'(troca), 32'h0);
    step();
    chk("auto_wrap", 32'(indice), 32'h0);
    chk("auto_wrap_troca", 32'(troca), 32'h1);
    chk("auto_wrap_out", 32'(out), 32'h7F);
    step(4);
    chk("auto_1", 32'(indice), 32'h1);
    chk("auto_1_out", 32'(out), 32'h1C);

    // pause freezes index and prescaler
    pausa = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pause_indice", 32'(indice), 32'h1);
      chk("pause_troca", 32'(troca), 32'h0);
    end
    pausa = 1'b0;
    step(4);
    chk("resume_tick", 32'(indice), 32'h2);

    // request in the tick cycle discards the tick and restarts the prescaler
    step(3);
    pedir = 1'b1; sel_manual = 2'd1;
    step();
    pedir = 1'b0;
    chk("prio_indice", 32'(indice), 32'h1);
    step(3);
    chk("prio_hold", 32'(indice), 32'h1);
    step();
    chk("prio_next_tick", 32'(indice), 32'h2);
    chk("prio_next_troca", 32'(troca), 32'h1);

    // reset mid-rotation with contador at 2
    step(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_indice", 32'(indice), 32'h0);
    chk("midrst_out", 32'(out), 32'h0);
    step(3);
    chk("midrst_hold", 32'(indice), 32'h0);
    step();
    chk("midrst_tick", 32'(indice), 32'h1);

    // three-map build: out-of-range request ignored
    b_pedir = 1'b1; b_sel = 2'd1;
    step();
    b_pedir = 1'b0;
    chk("n3_indice", 32'(b_indice), 32'h1);
    chk("n3_out", 32'(b_out), 32'h22);
    step();
    b_pedir = 1'b1; b_sel = 2'd3;
    step();
    b_pedir = 1'b0;
    chk("n3_oor_indice", 32'(b_indice), 32'h1);
    chk("n3_oor_out", 32'(b_out), 32'h22);
    chk("n3_oor_troca", 32'(b_troca), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
